// File: rtl/pwm_cfg_arbiter.sv
// Round-robin arbiter between two register-write requesters feeding the PWM
// configuration registers; the duty cycle is double-buffered and committed on pwm_wrap.
module pwm_cfg_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [6:0]  a_addr,
    input  logic [7:0]  a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [6:0]  b_addr,
    input  logic [7:0]  b_data,
    output logic        b_ready,
    input  logic        pwm_wrap,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm_mode,
    output logic [7:0]  pwm_duty_cycle,
    output logic        duty_pending,
    output logic        addr_err
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t     last_grant;
    grant_t     last_grant_next;
    logic [7:0] duty_shadow;
    logic       xfer;
    logic [6:0] xfer_addr;
    logic [7:0] xfer_data;
    logic       wr_duty;

    // Ties go to whichever side did not win the last transfer; no grants in reset.
    always_comb begin
        a_ready         = 1'b0;
        b_ready         = 1'b0;
        last_grant_next = last_grant;
        if (!rst) begin
            if (a_valid && (!b_valid || last_grant == GRANT_B)) begin
                a_ready         = 1'b1;
                last_grant_next = GRANT_A;
            end else if (b_valid) begin
                b_ready         = 1'b1;
                last_grant_next = GRANT_B;
            end
        end
    end

    always_comb begin
        xfer      = a_ready | b_ready;
        xfer_addr = a_ready ? a_addr : b_addr;
        xfer_data = a_ready ? a_data : b_data;
        wr_duty   = xfer && (xfer_addr == 7'h04);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant     <= GRANT_B;
            en_out         <= 16'h0000;
            en_pwm_mode    <= 16'h0000;
            pwm_duty_cycle <= 8'h00;
            duty_shadow    <= 8'h00;
            duty_pending   <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            last_grant <= last_grant_next;
            addr_err   <= xfer && (xfer_addr > 7'h04);
            if (xfer) begin
                case (xfer_addr)
                    7'h00:   en_out[7:0]       <= xfer_data;
                    7'h01:   en_out[15:8]      <= xfer_data;
                    7'h02:   en_pwm_mode[7:0]  <= xfer_data;
                    7'h03:   en_pwm_mode[15:8] <= xfer_data;
                    default: ;
                endcase
            end
            // A wrap commits the shadow held before this edge, even if a new write lands now.
            if (pwm_wrap && duty_pending) begin
                pwm_duty_cycle <= duty_shadow;
            end
            if (wr_duty) begin
                duty_shadow  <= xfer_data;
                duty_pending <= 1'b1;
            end else if (pwm_wrap) begin
                duty_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed self-checking bench for pwm_cfg_arbiter: arbitration, register writes,
// duty shadow commit on pwm_wrap, unmapped-address pulses and reset priority.
module tb_pwm_cfg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [6:0]  a_addr;
    logic [7:0]  a_data;
    logic        a_ready;
    logic        b_valid;
    logic [6:0]  b_addr;
    logic [7:0]  b_data;
    logic        b_ready;
    logic        pwm_wrap;
    logic [15:0] en_out;
    logic [15:0] en_pwm_mode;
    logic [7:0]  pwm_duty_cycle;
    logic        duty_pending;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_cfg_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .pwm_wrap       (pwm_wrap),
        .en_out         (en_out),
        .en_pwm_mode    (en_pwm_mode),
        .pwm_duty_cycle (pwm_duty_cycle),
        .duty_pending   (duty_pending),
        .addr_err       (addr_err)
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ready(input string tag, input logic exp_a, input logic exp_b);
        #1;
        check({tag, "_a_ready"}, {15'd0, a_ready}, {15'd0, exp_a});
        check({tag, "_b_ready"}, {15'd0, b_ready}, {15'd0, exp_b});
    endtask

    // Requesters must hold their request stable until it is accepted.
    logic       a_hold = 1'b0;
    logic       b_hold = 1'b0;
    logic [6:0] a_addr_q;
    logic [7:0] a_data_q;
    logic [6:0] b_addr_q;
    logic [7:0] b_data_q;
    always @(posedge clk) begin
        if (!rst && a_hold) begin
            assert (a_valid && a_addr == a_addr_q && a_data == a_data_q)
            else begin
                errors++;
                $error("[TB] FAIL a_hold_stable observed %b/%h/%h", a_valid, a_addr, a_data);
            end
        end
        if (!rst && b_hold) begin
            assert (b_valid && b_addr == b_addr_q && b_data == b_data_q)
            else begin
                errors++;
                $error("[TB] FAIL b_hold_stable observed %b/%h/%h", b_valid, b_addr, b_data);
            end
        end
        a_hold   = !rst && a_valid && !a_ready;
        b_hold   = !rst && b_valid && !b_ready;
        a_addr_q = a_addr;
        a_data_q = a_data;
        b_addr_q = b_addr;
        b_data_q = b_data;
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h00;
        b_valid = 1'b1; b_addr = 7'h00; b_data = 8'h00;
        pwm_wrap = 1'b0;
        step();
        step();
        check_ready("rst_init", 1'b0, 1'b0);
        check("rst_en_out", en_out, 16'h0000);
        check("rst_mode", en_pwm_mode, 16'h0000);
        check("rst_duty", {8'd0, pwm_duty_cycle}, 16'h0000);
        check("rst_pending", {15'd0, duty_pending}, 16'h0000);
        check("rst_addr_err", {15'd0, addr_err}, 16'h0000);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
        step();

        // Single A write to the upper enable byte
        a_valid = 1'b1; a_addr = 7'h01; a_data = 8'hA5;
        check_ready("a_single", 1'b1, 1'b0);
        step();
        a_valid = 1'b0;
        check("a_single_en_out", en_out, 16'hA500);
        check("a_single_mode", en_pwm_mode, 16'h0000);
        check("a_single_duty", {8'd0, pwm_duty_cycle}, 16'h0000);

        // Reset restores last_grant=B so A wins the first tie
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_en_out", en_out, 16'h0000);
        a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 7'h02; b_data = 8'h33;
        check_ready("rr1", 1'b1, 1'b0);
        step();
        a_data = 8'h22;
        check_ready("rr2", 1'b0, 1'b1);
        check("rr1_en_out", en_out, 16'h0011);
        step();
        b_data = 8'h44;
        check_ready("rr3", 1'b1, 1'b0);
        check("rr2_mode", en_pwm_mode, 16'h0033);
        step();
        a_valid = 1'b0;
        check_ready("rr4", 1'b0, 1'b1);
        step();
        b_valid = 1'b0;
        check("rr_en_out", en_out, 16'h0022);
        check("rr_mode", en_pwm_mode, 16'h0044);

        // Duty shadow write by B, committed by a later wrap
        b_valid = 1'b1; b_addr = 7'h04; b_data = 8'h80;
        check_ready("duty_b", 1'b0, 1'b1);
        step();
        b_valid = 1'b0;
        check("duty_b_pending", {15'd0, duty_pending}, 16'h0001);
        check("duty_b_duty", {8'd0, pwm_duty_cycle}, 16'h0000);
        step();
        step();
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        check("wrap1_duty", {8'd0, pwm_duty_cycle}, 16'h0080);
        check("wrap1_pending", {15'd0, duty_pending}, 16'h0000);
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        check("wrap_idle_duty", {8'd0, pwm_duty_cycle}, 16'h0080);
        check("wrap_idle_pending", {15'd0, duty_pending}, 16'h0000);

        // Wrap coincident with a new shadow write
        a_valid = 1'b1; a_addr = 7'h04; a_data = 8'h40;
        step();
        a_data = 8'h90;
        pwm_wrap = 1'b1;
        check_ready("coinc", 1'b1, 1'b0);
        step();
        a_valid = 1'b0;
        pwm_wrap = 1'b0;
        check("coinc_duty", {8'd0, pwm_duty_cycle}, 16'h0040);
        check("coinc_pending", {15'd0, duty_pending}, 16'h0001);
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        check("coinc_wrap_duty", {8'd0, pwm_duty_cycle}, 16'h0090);
        check("coinc_wrap_pending", {15'd0, duty_pending}, 16'h0000);

        // Repeated shadow writes: last one wins
        b_valid = 1'b1; b_addr = 7'h04; b_data = 8'h11;
        step();
        b_data = 8'h22;
        step();
        b_valid = 1'b0;
        check("multi_duty_hold", {8'd0, pwm_duty_cycle}, 16'h0090);
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        check("multi_duty", {8'd0, pwm_duty_cycle}, 16'h0022);

        // Unmapped address
        a_valid = 1'b1; a_addr = 7'h7F; a_data = 8'hFF;
        check_ready("unmapped", 1'b1, 1'b0);
        step();
        a_valid = 1'b0;
        check("unmapped_err", {15'd0, addr_err}, 16'h0001);
        check("unmapped_en_out", en_out, 16'h0022);
        check("unmapped_mode", en_pwm_mode, 16'h0044);
        check("unmapped_duty", {8'd0, pwm_duty_cycle}, 16'h0022);
        check("unmapped_pending", {15'd0, duty_pending}, 16'h0000);
        step();
        check("unmapped_err_clear", {15'd0, addr_err}, 16'h0000);

        // Reset overrides pending shadow, requests and wrap
        b_valid = 1'b1; b_addr = 7'h04; b_data = 8'h55;
        step();
        b_valid = 1'b0;
        check("pre_rst_pending", {15'd0, duty_pending}, 16'h0001);
        rst = 1'b1;
        pwm_wrap = 1'b1;
        a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h77;
        b_valid = 1'b1; b_addr = 7'h03; b_data = 8'h66;
        check_ready("in_rst", 1'b0, 1'b0);
        step();
        check("rst3_en_out", en_out, 16'h0000);
        check("rst3_mode", en_pwm_mode, 16'h0000);
        check("rst3_duty", {8'd0, pwm_duty_cycle}, 16'h0000);
        check("rst3_pending", {15'd0, duty_pending}, 16'h0000);
        rst = 1'b0;
        pwm_wrap = 1'b0;
        check_ready("post_rst1", 1'b1, 1'b0);
        step();
        a_valid = 1'b0;
        check_ready("post_rst2", 1'b0, 1'b1);
        step();
        b_valid = 1'b0;
        check("post_rst_en_out", en_out, 16'h7700);
        check("post_rst_mode", en_pwm_mode, 16'h6600);
        pwm_wrap = 1'b1;
        step();
        pwm_wrap = 1'b0;
        check("post_rst_duty", {8'd0, pwm_duty_cycle}, 16'h0000);
        check("post_rst_pending", {15'd0, duty_pending}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
